// File: rtl/regfile_dbg_pkg.sv
// regfile_dbg_pkg
// Shared constants, debug command encodings and the FSM state type for the
// register-file debug port (regfile_dbg_port and regfile_write_arb).
package regfile_dbg_pkg;

  localparam int DATA_W   = 16;  // register data width
  localparam int ADDR_W   = 3;   // register index width
  localparam int NUM_REGS = 8;   // register count, index 0 is read-only

  // Debug command opcodes (cmd_op)
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CLEAR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/regfile_dbg_port_write_arb.sv
// regfile_write_arb
// Combinational CPU-priority mux for the register-file write port.
// Ports:
//   en              - write enable gate; 0 forces rf_reg_write low
//   cpu_reg_write / cpu_write_reg / cpu_write_data - writeback request
//   dbg_write / dbg_reg / dbg_data                 - debug FSM request
//   grant           - 1 when the debug side owns the port this cycle
//   rf_reg_write / rf_write_reg / rf_write_data    - to the register file
module regfile_write_arb
  import regfile_dbg_pkg::*;
(
  input  logic              en,
  input  logic              cpu_reg_write,
  input  logic [ADDR_W-1:0] cpu_write_reg,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_reg,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              grant,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  always_comb begin
    grant         = !cpu_reg_write;
    rf_reg_write  = 1'b0;
    rf_write_reg  = dbg_reg;
    rf_write_data = dbg_data;
    if (cpu_reg_write) begin
      rf_reg_write  = 1'b1;
      rf_write_reg  = cpu_write_reg;
      rf_write_data = cpu_write_data;
    end else begin
      rf_reg_write  = dbg_write;
    end
    // Reset overrides everything, including a CPU writeback.
    rf_reg_write = rf_reg_write & en;
  end

endmodule

// File: rtl/regfile_dbg_port.sv
// regfile_dbg_port
// Writer side of the 8x16 register-file port. Passes CPU writeback through
// to the register file and serves a debug command channel (WRITE, READ,
// CLEAR, NOP). CPU writeback always wins the write port; debug writes stall.
// Optional build macro: REGFILE_DBG_BYPASS_EN enables read-after-write
// forwarding of a same-cycle CPU write into a debug READ result.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_reg/cmd_data    - debug command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err           - debug response channel
//   dbg_busy                                       - FSM not idle
//   cpu_reg_write/cpu_write_reg/cpu_write_data     - writeback input
//   rf_reg_write/rf_write_reg/rf_write_data        - register-file write port
//   rf_read_reg/rf_read_data                       - register-file read port 2
module regfile_dbg_port
  import regfile_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_reg,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              dbg_busy,
  input  logic              cpu_reg_write,
  input  logic [ADDR_W-1:0] cpu_write_reg,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cmd_reg_reg, cmd_reg_next;
  logic [DATA_W-1:0] cmd_data_reg, cmd_data_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_err_reg, rsp_err_next;

  logic              grant;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_wreg;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] read_value;

`ifdef REGFILE_DBG_BYPASS_EN
  // Forward a CPU write landing on the register being read this cycle.
  assign read_value = (cpu_reg_write && (cpu_write_reg == cmd_reg_reg) &&
                       (cmd_reg_reg != '0)) ? cpu_write_data : rf_read_data;
`else
  assign read_value = rf_read_data;
`endif

  regfile_write_arb u_arb (
    .en             (rst_n),
    .cpu_reg_write  (cpu_reg_write),
    .cpu_write_reg  (cpu_write_reg),
    .cpu_write_data (cpu_write_data),
    .dbg_write      (dbg_write),
    .dbg_reg        (dbg_wreg),
    .dbg_data       (dbg_wdata),
    .grant          (grant),
    .rf_reg_write   (rf_reg_write),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data)
  );

  always_comb begin
    state_next    = state_reg;
    cmd_reg_next  = cmd_reg_reg;
    cmd_data_next = cmd_data_reg;
    cnt_next      = cnt_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    dbg_write     = 1'b0;
    dbg_wreg      = cmd_reg_reg;
    dbg_wdata     = cmd_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_reg_next  = cmd_reg;
          cmd_data_next = cmd_data;
          rsp_data_next = '0;
          rsp_err_next  = 1'b0;
          case (cmd_op)
            OP_WRITE: state_next = ST_WRITE;
            OP_READ:  state_next = ST_READ;
            OP_CLEAR: begin
              state_next = ST_CLEAR;
              cnt_next   = ADDR_W'(1);
            end
            default:  state_next = ST_RESP;
          endcase
        end
      end
      ST_WRITE: begin
        if (cmd_reg_reg == '0) begin
          rsp_err_next = 1'b1;
          state_next   = ST_RESP;
        end else if (grant) begin
          dbg_write  = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_READ: begin
        rsp_data_next = read_value;
        state_next    = ST_RESP;
      end
      ST_CLEAR: begin
        dbg_wreg  = cnt_reg;
        dbg_wdata = '0;
        // A CPU write cycle freezes the sweep; no debug write is lost.
        if (grant) begin
          dbg_write = 1'b1;
          if (cnt_reg == LAST_REG) state_next = ST_RESP;
          else                     cnt_next   = cnt_reg + ADDR_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_err_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cmd_reg_reg  <= '0;
      cmd_data_reg <= '0;
      cnt_reg      <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg_reg  <= cmd_reg_next;
      cmd_data_reg <= cmd_data_next;
      cnt_reg      <= cnt_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign dbg_busy    = (state_reg != ST_IDLE);
  assign rsp_valid   = (state_reg == ST_RESP);
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign rf_read_reg = cmd_reg_reg;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// tb_regfile_dbg_port
// Self-checking bench for regfile_dbg_port: directed scenarios followed by
// randomized commands with random CPU writeback traffic, all checked against
// a transaction-level model of the register file contents.
module tb_regfile_dbg_port;
  import regfile_dbg_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_reg;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              dbg_busy;
  logic              cpu_reg_write;
  logic [ADDR_W-1:0] cpu_write_reg;
  logic [DATA_W-1:0] cpu_write_data;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;

  always #5 clk = ~clk;

  regfile_dbg_port dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .dbg_busy(dbg_busy),
    .cpu_reg_write(cpu_reg_write), .cpu_write_reg(cpu_write_reg),
    .cpu_write_data(cpu_write_data),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data)
  );

  // Register file environment driven by the DUT write port.
  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  assign rf_read_data = rf_mem[rf_read_reg];
  always @(posedge clk)
    if (rf_reg_write && rf_write_reg != '0) rf_mem[rf_write_reg] <= rf_write_data;

  // Reference model: expected architectural register contents.
  logic [DATA_W-1:0] exp_regs [NUM_REGS];

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_DBG_BYPASS_EN
  bit bypass_on = 1'b1;
`else
  bit bypass_on = 1'b0;
`endif

  int                cpu_rate = 0;
  int                force_a = -1;
  int                force_b = -1;
  logic [ADDR_W-1:0] force_reg = '0;
  logic [DATA_W-1:0] force_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_cpu(input int k);
    if (k == force_a || k == force_b) begin
      cpu_reg_write  = 1'b1;
      cpu_write_reg  = force_reg;
      cpu_write_data = force_data;
    end else if (int'($urandom_range(99)) < cpu_rate) begin
      cpu_reg_write  = 1'b1;
      cpu_write_reg  = ADDR_W'($urandom_range(1, NUM_REGS - 1));
      cpu_write_data = DATA_W'($urandom);
    end else begin
      cpu_reg_write  = 1'b0;
    end
  endtask

  // Called just after an edge: folds the CPU write of the past cycle into the model.
  function automatic bit commit_cpu();
    if (cpu_reg_write) begin
      if (cpu_write_reg != '0) exp_regs[cpu_write_reg] = cpu_write_data;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_port(input string tag, input bit dbg_exp,
                            input logic [ADDR_W-1:0] dreg, input logic [DATA_W-1:0] ddata);
    if (cpu_reg_write) begin
      chk({tag, "_cpu_we"}, rf_reg_write, 1'b1);
      chk({tag, "_cpu_reg"}, rf_write_reg, cpu_write_reg);
      chk({tag, "_cpu_data"}, rf_write_data, cpu_write_data);
    end else if (dbg_exp) begin
      chk({tag, "_dbg_we"}, rf_reg_write, 1'b1);
      chk({tag, "_dbg_reg"}, rf_write_reg, dreg);
      chk({tag, "_dbg_data"}, rf_write_data, ddata);
    end else begin
      chk({tag, "_idle_we"}, rf_reg_write, 1'b0);
    end
  endtask

  // Runs one full debug command from an IDLE cycle (entered at edge+1).
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [ADDR_W-1:0] r,
                        input logic [DATA_W-1:0] d, input int hold);
    wr_t q[$];
    wr_t w;
    logic [DATA_W-1:0] exp_data;
    bit exp_err, one_shot, done, b;
    chk({tag, "_ready_idle"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_data = d;
    drive_cpu(-2);
    #1 check_port({tag, "_acc"}, 1'b0, '0, '0);
    @(posedge clk); #1;
    b = commit_cpu();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_reg = ADDR_W'($urandom); cmd_data = DATA_W'($urandom);
    if (op == OP_WRITE && r != '0) begin w.r = r; w.d = d; q.push_back(w); end
    if (op == OP_CLEAR)
      for (int i = 1; i < NUM_REGS; i++) begin w.r = ADDR_W'(i); w.d = '0; q.push_back(w); end
    exp_data = '0;
    exp_err  = (op == OP_WRITE && r == '0);
    one_shot = (op == OP_READ) || exp_err;
    done     = (op == OP_NOP);
    for (int k = 0; k < 100; k++) begin
      chk({tag, "_rsp_valid_timing"}, rsp_valid, done);
      if (done) break;
      chk({tag, "_busy"}, dbg_busy, 1'b1);
      chk({tag, "_ready_busy"}, cmd_ready, 1'b0);
      chk({tag, "_read_reg"}, rf_read_reg, r);
      drive_cpu(k);
      #1;
      if (q.size() != 0) check_port(tag, 1'b1, q[0].r, q[0].d);
      else               check_port(tag, 1'b0, '0, '0);
      if (op == OP_READ)
        exp_data = (bypass_on && cpu_reg_write && cpu_write_reg == r && r != '0)
                   ? cpu_write_data : exp_regs[r];
      @(posedge clk); #1;
      if (!commit_cpu() && q.size() != 0) begin
        w = q.pop_front();
        exp_regs[w.r] = w.d;
      end
      done = one_shot || (op != OP_NOP && q.size() == 0);
    end
    if (!done) chk({tag, "_timeout"}, 1'b0, 1'b1);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, "_rsp_data"}, rsp_data, exp_data);
      chk({tag, "_rsp_err"}, rsp_err, exp_err);
      chk({tag, "_ready_resp"}, cmd_ready, 1'b0);
      chk({tag, "_read_reg_resp"}, rf_read_reg, r);
      rsp_ready = (h == hold);
      drive_cpu(-2);
      #1 check_port({tag, "_resp"}, 1'b0, '0, '0);
      @(posedge clk); #1;
      b = commit_cpu();
    end
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, rsp_valid, 1'b0);
    chk({tag, "_ready_back"}, cmd_ready, 1'b1);
    chk({tag, "_busy_back"}, dbg_busy, 1'b0);
    $display("txn %s op=%0d reg=%0d data=%h rsp=%h err=%0d", tag, op, r, d, exp_data, exp_err);
  endtask

  initial begin
    bit b;
    rf_mem[0] = '0; exp_regs[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rf_mem[i] = DATA_W'($urandom); exp_regs[i] = rf_mem[i];
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    cpu_reg_write = 1'b1; cpu_write_reg = 3'd3; cpu_write_data = 16'hAAAA;

    // Reset: write port forced off even with CPU traffic; outputs at reset values.
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_we_forced", rf_reg_write, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", dbg_busy, 1'b0);
    chk("rst_read_reg", rf_read_reg, 3'd0);
    cpu_reg_write = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd("wr3", OP_WRITE, 3'd3, 16'hBEEF, 0);
    do_cmd("wr0", OP_WRITE, 3'd0, 16'h1234, 3);
    do_cmd("wr5", OP_WRITE, 3'd5, 16'h00A5, 0);
    do_cmd("rd5", OP_READ, 3'd5, 16'h0, 1);

    // CLEAR with two mid-sweep CPU writes to reg6.
    for (int i = 4; i < NUM_REGS; i++) do_cmd("prefill", OP_WRITE, ADDR_W'(i), DATA_W'(16'h1000 + i), 0);
    force_a = 2; force_b = 3; force_reg = 3'd6; force_data = 16'h5555;
    do_cmd("clr_stall", OP_CLEAR, 3'd0, 16'h0, 1);
    force_a = -1; force_b = -1;

    // READ with a same-cycle CPU write to the same register.
    do_cmd("wr2", OP_WRITE, 3'd2, 16'h1111, 0);
    force_a = 0; force_reg = 3'd2; force_data = 16'h7777;
    do_cmd("rd2_raw", OP_READ, 3'd2, 16'h0, 0);
    force_a = -1;
    do_cmd("nop", OP_NOP, 3'd4, 16'hFFFF, 2);

    // Reset in the middle of a CLEAR, at counter 4.
    for (int i = 4; i < NUM_REGS; i++) do_cmd("prefill2", OP_WRITE, ADDR_W'(i), DATA_W'(16'h2000 + i), 0);
    cmd_valid = 1'b1; cmd_op = OP_CLEAR; cmd_reg = 3'd0; cmd_data = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      exp_regs[i] = '0;
    end
    rst_n = 1'b0;
    cpu_reg_write = 1'b1; cpu_write_reg = 3'd5; cpu_write_data = 16'hDEAD;
    #1 chk("midrst_we_forced", rf_reg_write, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; cpu_reg_write = 1'b0;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_busy", dbg_busy, 1'b0);
    chk("midrst_rsp_data", rsp_data, 16'h0);
    for (int i = 1; i < NUM_REGS; i++) chk("midrst_reg", rf_mem[i], exp_regs[i]);
    $display("txn midrst clear abandoned at reg 4");

    // Randomized commands under random CPU writeback traffic.
    cpu_rate = 30;
    for (int n = 0; n < 40; n++)
      do_cmd("rand", 2'($urandom_range(3)), ADDR_W'($urandom_range(NUM_REGS - 1)),
             DATA_W'($urandom), int'($urandom_range(3)));
    cpu_rate = 0;
    cpu_reg_write = 1'b0;
    @(posedge clk); #1;
    b = commit_cpu();

    for (int i = 0; i < NUM_REGS; i++) chk("final_reg", rf_mem[i], exp_regs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
